// File: rtl/mem_port_sequencer_pkg.sv
// Shared types and constants for the fetch/data RAM port sequencer.
// Holds the FSM state encoding, grant ids and default bus widths.
package mem_port_sequencer_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    // Clamp the latency into 1..15 so a bad parameter cannot stall WAIT forever.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int v;
        v = lat;
        if (v < 1) begin
            v = 1;
        end
        if (v > 15) begin
            v = 15;
        end
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/mem_port_sequencer_rr_arbiter2.sv
// Two-way alternating-priority arbiter (fetch vs data), combinational grant.
// Grant is only issued while i_en is high; a tie goes to whoever was not granted last.
module rr_arbiter2
    import mem_port_sequencer_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_fetch,
    input  logic i_req_data,
    input  logic i_en,
    output logic o_gnt_fetch,
    output logic o_gnt_data
);

    logic r_last;
    logic w_gnt_fetch;
    logic w_gnt_data;

    always_comb begin
        w_gnt_fetch = i_en && i_req_fetch && (!i_req_data || (r_last == GNT_DATA));
        w_gnt_data  = i_en && i_req_data  && (!i_req_fetch || (r_last == GNT_FETCH));
    end

    // Reset to DATA so fetch wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= GNT_DATA;
        end else if (w_gnt_fetch) begin
            r_last <= GNT_FETCH;
        end else if (w_gnt_data) begin
            r_last <= GNT_DATA;
        end
    end

    assign o_gnt_fetch = w_gnt_fetch;
    assign o_gnt_data  = w_gnt_data;

endmodule

// File: rtl/mem_port_sequencer.sv
// Sequences the single RAM port between instruction fetch and data load/store.
// Read ack MEM_LATENCY+2 cycles after request, write ack after 2; one IDLE cycle between transactions.
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_ack,
    output logic [DATA_W-1:0] o_fetch_data,
    input  logic              i_data_req,
    input  logic              i_data_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    output logic              o_data_ack,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    state_t             r_state;
    state_t             w_next;
    logic               r_gnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_fetch_data;
    logic [DATA_W-1:0]  r_data_rdata;
    logic               w_gnt_fetch;
    logic               w_gnt_data;
    logic               w_arb_en;
    logic               w_cnt_last;

    assign w_arb_en   = (r_state == IDLE);
    assign w_cnt_last = (r_cnt == CNT_W'(1));

    rr_arbiter2 u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_fetch (i_fetch_req),
        .i_req_data  (i_data_req),
        .i_en        (w_arb_en),
        .o_gnt_fetch (w_gnt_fetch),
        .o_gnt_data  (w_gnt_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_fetch_ack  = 1'b0;
        o_data_ack   = 1'b0;
        o_busy       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_gnt_fetch || w_gnt_data) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                o_mem_read  = !r_we;
                o_mem_write = r_we;
                w_next      = r_we ? RESP : WAIT;
            end
            WAIT: begin
                if (w_cnt_last) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                o_fetch_ack = (r_gnt == GNT_FETCH);
                o_data_ack  = (r_gnt == GNT_DATA);
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Everything the transaction needs is captured at grant; later input changes are ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt       <= GNT_DATA;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_gnt_fetch) begin
            r_gnt       <= GNT_FETCH;
            r_we        <= 1'b0;
            r_mem_addr  <= i_fetch_addr;
            r_mem_wdata <= '0;
        end else if (w_gnt_data) begin
            r_gnt       <= GNT_DATA;
            r_we        <= i_data_we;
            r_mem_addr  <= i_data_addr;
            r_mem_wdata <= i_data_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ACCESS) begin
            r_cnt <= lat_load(MEM_LATENCY);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Read-data registers hold until the next read for the same requester.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_data <= '0;
            r_data_rdata <= '0;
        end else if ((r_state == WAIT) && w_cnt_last) begin
            if (r_gnt == GNT_FETCH) begin
                r_fetch_data <= i_mem_rdata;
            end else begin
                r_data_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_fetch_data = r_fetch_data;
    assign o_data_rdata = r_data_rdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: transaction-level model checked every cycle, plus directed literal checks.
// Three instances: default latency (main), latency 1 and latency 15 for the sweep.
module tb_mem_port_sequencer;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        f_req, f_ack, d_req, d_we, d_ack, m_read, m_write, busy;
    logic [8:0]  f_addr, d_addr, m_addr;
    logic [31:0] f_data, d_wdata, d_rdata, m_wdata, m_rdata;

    logic        s1_req, s1_ack, s1_dack, s1_mrd, s1_mwr, s1_busy;
    logic [8:0]  s1_addr, s1_maddr;
    logic [31:0] s1_data, s1_drd, s1_mwd, s1_mrdata;
    logic        s15_req, s15_ack, s15_dack, s15_mrd, s15_mwr, s15_busy;
    logic [8:0]  s15_addr, s15_maddr;
    logic [31:0] s15_data, s15_drd, s15_mwd, s15_mrdata;

    logic [31:0] ram [512];
    bit          ram_ready;
    int          rd_cnt, s1_cnt, s15_cnt;

    int n_checks;
    int n_fail;

    mem_port_sequencer #(.ADDR_W(9), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetch_req(f_req), .i_fetch_addr(f_addr), .o_fetch_ack(f_ack), .o_fetch_data(f_data),
        .i_data_req(d_req), .i_data_we(d_we), .i_data_addr(d_addr), .i_data_wdata(d_wdata),
        .o_data_ack(d_ack), .o_data_rdata(d_rdata),
        .o_mem_addr(m_addr), .o_mem_read(m_read), .o_mem_write(m_write), .o_mem_wdata(m_wdata),
        .i_mem_rdata(m_rdata), .o_busy(busy)
    );

    mem_port_sequencer #(.ADDR_W(9), .DATA_W(32), .MEM_LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetch_req(s1_req), .i_fetch_addr(s1_addr), .o_fetch_ack(s1_ack), .o_fetch_data(s1_data),
        .i_data_req(1'b0), .i_data_we(1'b0), .i_data_addr(9'd0), .i_data_wdata(32'd0),
        .o_data_ack(s1_dack), .o_data_rdata(s1_drd),
        .o_mem_addr(s1_maddr), .o_mem_read(s1_mrd), .o_mem_write(s1_mwr), .o_mem_wdata(s1_mwd),
        .i_mem_rdata(s1_mrdata), .o_busy(s1_busy)
    );

    mem_port_sequencer #(.ADDR_W(9), .DATA_W(32), .MEM_LATENCY(15)) dut_l15 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetch_req(s15_req), .i_fetch_addr(s15_addr), .o_fetch_ack(s15_ack), .o_fetch_data(s15_data),
        .i_data_req(1'b0), .i_data_we(1'b0), .i_data_addr(9'd0), .i_data_wdata(32'd0),
        .o_data_ack(s15_dack), .o_data_rdata(s15_drd),
        .o_mem_addr(s15_maddr), .o_mem_read(s15_mrd), .o_mem_write(s15_mwr), .o_mem_wdata(s15_mwd),
        .i_mem_rdata(s15_mrdata), .o_busy(s15_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read data is valid only in the cycle exactly L cycles after the read strobe cycle ends.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram[i] = 32'hA500_0000 | i;
            ram[16] = 32'hDEAD_BEEF;
            ram_ready = 1'b1;
        end
        if (m_write) ram[m_addr] = m_wdata;
        rd_cnt  <= m_read  ? LAT : ((rd_cnt  != 0) ? rd_cnt  - 1 : 0);
        s1_cnt  <= s1_mrd  ? 1   : ((s1_cnt  != 0) ? s1_cnt  - 1 : 0);
        s15_cnt <= s15_mrd ? 15  : ((s15_cnt != 0) ? s15_cnt - 1 : 0);
    end

    assign m_rdata    = (rd_cnt  == 1) ? ram[m_addr]    : 32'hBADB_AD00;
    assign s1_mrdata  = (s1_cnt  == 1) ? ram[s1_maddr]  : 32'hBADB_AD01;
    assign s15_mrdata = (s15_cnt == 1) ? ram[s15_maddr] : 32'hBADB_AD02;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction described by its grant offset.
    logic [31:0] mmem [512];
    bit          md_init, md_active, md_who, md_we, md_last;
    int          md_off, md_ackoff;
    logic [8:0]  md_addr, md_maddr;
    logic [31:0] md_wdata, md_fd, md_dr;

    always @(negedge clk) begin
        if (!md_init) begin
            for (int i = 0; i < 512; i++) mmem[i] = 32'hA500_0000 | i;
            mmem[16] = 32'hDEAD_BEEF;
            md_init = 1'b1;
        end
        if (!rst_n) begin
            check("rst_busy", busy, 0);       check("rst_read", m_read, 0);
            check("rst_write", m_write, 0);   check("rst_fack", f_ack, 0);
            check("rst_dack", d_ack, 0);      check("rst_maddr", m_addr, 0);
            check("rst_mwdata", m_wdata, 0);  check("rst_fdata", f_data, 0);
            check("rst_drdata", d_rdata, 0);
            md_active = 0; md_last = 1; md_fd = 0; md_dr = 0; md_maddr = 0;
        end else if (!md_active) begin
            check("idle_busy", busy, 0);   check("idle_read", m_read, 0);
            check("idle_write", m_write, 0);
            check("idle_fack", f_ack, 0);  check("idle_dack", d_ack, 0);
            check("idle_maddr", m_addr, md_maddr);
            check("idle_fdata", f_data, md_fd); check("idle_drdata", d_rdata, md_dr);
            if (f_req || d_req) begin
                md_who    = (f_req && d_req) ? !md_last : d_req;
                md_we     = md_who ? d_we : 1'b0;
                md_addr   = md_who ? d_addr : f_addr;
                md_wdata  = d_wdata;
                md_last   = md_who;
                md_maddr  = md_addr;
                md_ackoff = md_we ? 2 : LAT + 2;
                md_off    = 1;
                md_active = 1;
            end
        end else begin
            if (md_off == 1 && md_we) mmem[md_addr] = md_wdata;
            if (md_off == md_ackoff && !md_we) begin
                if (md_who) md_dr = mmem[md_addr];
                else        md_fd = mmem[md_addr];
            end
            check("busy", busy, 1);
            check("mem_read", m_read, (md_off == 1) && !md_we);
            check("mem_write", m_write, (md_off == 1) && md_we);
            check("fetch_ack", f_ack, (md_off == md_ackoff) && !md_who);
            check("data_ack", d_ack, (md_off == md_ackoff) && md_who);
            check("mem_addr", m_addr, md_maddr);
            check("fetch_data", f_data, md_fd);
            check("data_rdata", d_rdata, md_dr);
            if (md_off == 1 && md_we) check("mem_wdata", m_wdata, md_wdata);
            if (md_off == md_ackoff) md_active = 0;
            else md_off++;
        end
    end

    // Observation window recorders, relative to the cycle watch() starts in.
    int fa_first, da_first, s1_first, s15_first, rd_first, wr_first, nrd, nwr, nboth;
    bit order [$];

    task automatic watch(input int ncyc, input bit drop);
        fa_first = -1; da_first = -1; s1_first = -1; s15_first = -1;
        rd_first = -1; wr_first = -1; nrd = 0; nwr = 0; nboth = 0;
        order.delete();
        for (int k = 0; k < ncyc; k++) begin
            if (m_read)  begin nrd++; if (rd_first < 0) rd_first = k; end
            if (m_write) begin nwr++; if (wr_first < 0) wr_first = k; end
            if (m_read && m_write) nboth++;
            if (f_ack) begin order.push_back(1'b0); if (fa_first < 0) fa_first = k; if (drop) f_req = 0; end
            if (d_ack) begin order.push_back(1'b1); if (da_first < 0) da_first = k; if (drop) d_req = 0; end
            if (s1_ack  && s1_first  < 0) begin s1_first  = k; if (drop) s1_req  = 0; end
            if (s15_ack && s15_first < 0) begin s15_first = k; if (drop) s15_req = 0; end
            @(posedge clk); #2;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 0; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        s1_req = 0; s1_addr = 0; s15_req = 0; s15_addr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        next_cycle();

        // Single fetch read
        f_req = 1; f_addr = 9'h010; #1;
        watch(8, 1);
        check("fetch_ack_cycle", fa_first, 4);
        check("fetch_rd_cycle", rd_first, 1);
        check("fetch_nrd", nrd, 1);
        check("fetch_data_lit", f_data, 32'hDEAD_BEEF);

        // Data store, then load back
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 9'h020; d_wdata = 32'h1234_5678; #1;
        watch(6, 1);
        check("store_ack_cycle", da_first, 2);
        check("store_wr_cycle", wr_first, 1);
        check("store_nwr", nwr, 1);
        check("store_nrd", nrd, 0);
        next_cycle();
        d_req = 1; d_we = 0; d_addr = 9'h020; d_wdata = 32'h0; #1;
        watch(8, 1);
        check("load_ack_cycle", da_first, 4);
        check("load_data_lit", d_rdata, 32'h1234_5678);

        // Simultaneous requests straight from reset, both held
        next_cycle(); rst_n = 0;
        next_cycle(); rst_n = 1;
        next_cycle();
        f_req = 1; f_addr = 9'h011; d_req = 1; d_we = 0; d_addr = 9'h022; #1;
        watch(20, 0);
        f_req = 0; d_req = 0;
        check("tie_nacks", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) check("tie_order", order[i], i % 2);
        check("tie_first_fetch", fa_first, 4);
        check("tie_first_data", da_first, 9);
        check("tie_both_strobes", nboth, 0);
        check("tie_drdata_lit", d_rdata, 32'hA500_0022);
        watch(4, 0);

        // Address changed after grant
        next_cycle();
        f_req = 1; f_addr = 9'h030;
        next_cycle();
        f_addr = 9'h1FF; #1;
        check("late_addr_lit", m_addr, 9'h030);
        watch(8, 1);
        check("late_ack_cycle", fa_first, 3);
        check("late_data_lit", f_data, 32'hA500_0030);

        // Reset in the WAIT phase of a read
        next_cycle();
        f_req = 1; f_addr = 9'h012;
        next_cycle();
        next_cycle();
        rst_n = 0; f_req = 0; #1;
        check("midrst_busy", busy, 0);
        check("midrst_read", m_read, 0);
        check("midrst_fack", f_ack, 0);
        next_cycle();
        rst_n = 1; #1;
        watch(8, 0);
        check("midrst_no_ack", fa_first, -1);
        check("midrst_no_read", nrd, 0);
        next_cycle();
        f_req = 1; f_addr = 9'h013; #1;
        watch(8, 1);
        check("postrst_ack_cycle", fa_first, 4);
        check("postrst_data_lit", f_data, 32'hA500_0013);

        // Latency sweep on the L=1 and L=15 instances
        next_cycle();
        s1_req = 1; s1_addr = 9'h005; s15_req = 1; s15_addr = 9'h006; #1;
        watch(22, 1);
        check("lat1_ack_cycle", s1_first, 3);
        check("lat15_ack_cycle", s15_first, 17);
        check("lat1_data", s1_data, 32'hA500_0005);
        check("lat15_data", s15_data, 32'hA500_0006);
        check("lat_idle_busy", {30'd0, s1_busy, s15_busy}, 0);

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Sequences the single shared RAM port between two requesters: instruction fetch (driven by the control unit's fetch phase) and data load/store (driven by its execute phase).
- Drives the memory address, read and write strobes, waits out a fixed read latency, and returns the read data with a one-cycle acknowledge.
- Sits between the control unit and the RAM / MAR / MDR path.
- Arbitration is alternating priority when both requesters are pending.

Parameters:
- ADDR_W, 9, memory word address width (512-word RAM).
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the end of the ACCESS cycle until mem_rdata is valid; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; level signal, held until fetch_ack.
- fetch_addr  in  ADDR_W  fetch word address; sampled at grant.
- fetch_ack  out  1  one-cycle pulse; fetch_data is valid in the same cycle.
- fetch_data  out  DATA_W  registered fetch read data.
- data_req  in  1  data request; level signal, held until data_ack.
- data_we  in  1  1 = store, 0 = load; sampled at grant.
- data_addr  in  ADDR_W  data word address; sampled at grant.
- data_wdata  in  DATA_W  store data; sampled at grant.
- data_ack  out  1  one-cycle completion pulse.
- data_rdata  out  DATA_W  registered load data; valid with data_ack when data_we was 0.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP.
  - IDLE: if any request is high, grant one requester, latch its address, we and wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (1 cycle): mem_addr and mem_wdata hold the latched values. mem_read = !we, mem_write = we. Next state is RESP for a write, WAIT for a read.
  - WAIT: 5-bit down-counter loaded with MEM_LATENCY at ACCESS exit. mem_rdata is captured into the granted requester's data register at the end of the cycle in which the counter equals 1; the state then goes to RESP.
  - RESP (1 cycle): the granted requester's ack = 1, then go to IDLE.
- Latency, counting the IDLE cycle in which the request is first high as cycle 0:
  - read ack in cycle MEM_LATENCY+2 (cycle 4 at default);
  - write ack in cycle 2.
- Strobes:
  - mem_read and mem_write are high only in ACCESS and are never high together.
  - mem_addr and mem_wdata hold their values from grant until the next grant.
- Arbitration:
  - A single pending request is granted immediately.
  - If both are pending, grant the requester that was not granted last.
  - The last-grant register resets to DATA, so fetch wins the first tie.
- Back-to-back transactions:
  - A request still high in the IDLE cycle after RESP is a new request.
  - Minimum gap between consecutive transactions is one IDLE cycle.
- Protocol violations:
  - A request dropped before its ack is ignored; the transaction still completes and the ack still pulses.
  - Inputs changing after grant have no effect on the current transaction.
- Reset low, at any time including mid-transaction, immediately forces:
  - state IDLE; all strobes, acks and busy to 0;
  - mem_addr, mem_wdata, fetch_data, data_rdata and the counter to 0;
  - last-grant to DATA.
- No transaction resumes after reset; requesters re-issue.
- The read-data registers are not cleared at ack and hold their value until the next read for that requester.

Decomposition:
- Shared package:
  - state enum: IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  - grant ids: GNT_FETCH = 1'b0, GNT_DATA = 1'b1;
  - default ADDR_W and DATA_W constants.
- One natural sub-module, rr_arbiter2: two request inputs, an enable input (high in IDLE), one-hot grant outputs, and the last-grant register, with the same Clock and Reset.
- The FSM, latency counter and data registers stay in mem_port_sequencer.

Test Plan:
- Single fetch read: fetch_req = 1, fetch_addr = 9'h010, RAM holds 32'hDEADBEEF, MEM_LATENCY = 2 -> mem_read high in cycle 1 with mem_addr = 9'h010; fetch_ack in cycle 4 with fetch_data = 32'hDEADBEEF; busy high in cycles 1-4.
- Data store: data_req = 1, data_we = 1, data_addr = 9'h020, data_wdata = 32'h12345678 -> mem_write high in cycle 1 only; data_ack in cycle 2; mem_read never high.
- Simultaneous requests from reset, both held -> fetch granted first, then data, then fetch; acks strictly alternate; mem_read and mem_write never high together.
- Latency sweep: MEM_LATENCY = 1 and 15 -> read ack in cycle 3 and cycle 17 respectively, with correct data.
- Reset during WAIT: Reset low in cycle 2 of a read -> busy, mem_read and acks at 0 immediately; no ack after release; the next request completes normally.
- Inputs changed after grant: fetch_addr changed in cycle 1 -> mem_addr keeps the value granted in cycle 0.
